// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared op encodings, FSM states and width defaults for the memory stage
package mem_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 11;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_LOAD  = 3'd1,
    OP_STORE = 3'd2,
    OP_PUSH  = 3'd3,
    OP_POP   = 3'd4,
    OP_CALL  = 3'd5,
    OP_RET   = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SECOND = 1'b1
  } state_e;

endpackage

// File: rtl/data_mem.sv
// rtl/data_mem.sv - data memory with combinational read and synchronous write
module data_mem #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Contents are never cleared; a write becomes visible to reads on the next cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access stage: data memory, stack pointer, CALL/RET FSM and MEM/WB register
module mem_stage
  import mem_pkg::*;
#(
  parameter int                DATA_W  = DATA_W_DEF,
  parameter int                ADDR_W  = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] SP_INIT = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] alu_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [31:0]       pc_i,
  input  logic              reg_write_i,
  input  logic              mem_or_reg_i,
  input  logic              dst_or_private_i,
  input  logic [3:0]        reg_dst_i,
  output logic              stall_o,
  output logic              reg_write_o,
  output logic              mem_or_reg_o,
  output logic              dst_or_private_o,
  output logic [3:0]        reg_dst_o,
  output logic [DATA_W-1:0] alu_data_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic [31:0]       pc_o,
  output logic              pc_valid_o,
  output logic [ADDR_W-1:0] sp_o
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] TWO = ADDR_W'(2);

  op_e               op;
  state_e            state_q, state_d;
  op_e               held_q, held_d;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic [DATA_W-1:0] low_q, low_d;

  logic              we;
  logic [ADDR_W-1:0] waddr, raddr;
  logic [DATA_W-1:0] wdata, rdata;

  logic              bubble;
  logic [DATA_W-1:0] wb_mem;
  logic [31:0]       wb_pc;
  logic              wb_pc_valid;

  assign op   = op_e'(op_i);
  assign sp_o = sp_q;

  // A write in the reset cycle is dropped so an aborted CALL leaves only its first word.
  data_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_data_mem (
    .clk   (clk),
    .we    (we && !rst),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

  // Next-state, memory port steering and MEM/WB data selection.
  always_comb begin
    state_d     = ST_IDLE;
    held_d      = held_q;
    sp_d        = sp_q;
    low_d       = low_q;
    we          = 1'b0;
    waddr       = sp_q;
    wdata       = wdata_i;
    raddr       = alu_i[ADDR_W-1:0];
    stall_o     = 1'b0;
    bubble      = 1'b0;
    wb_mem      = '0;
    wb_pc       = pc_o;
    wb_pc_valid = 1'b0;
    if (state_q == ST_IDLE) begin
      case (op)
        OP_LOAD: begin
          raddr  = alu_i[ADDR_W-1:0];
          wb_mem = rdata;
        end
        OP_STORE: begin
          we    = 1'b1;
          waddr = alu_i[ADDR_W-1:0];
        end
        OP_PUSH: begin
          we    = 1'b1;
          waddr = sp_q;
          sp_d  = sp_q - ONE;
        end
        OP_POP: begin
          raddr  = sp_q + ONE;
          wb_mem = rdata;
          sp_d   = sp_q + ONE;
        end
        OP_CALL: begin
          we      = 1'b1;
          waddr   = sp_q;
          wdata   = DATA_W'(pc_i[31:16]);
          stall_o = 1'b1;
          bubble  = 1'b1;
          held_d  = OP_CALL;
          state_d = ST_SECOND;
        end
        OP_RET: begin
          raddr   = sp_q + ONE;
          low_d   = rdata;
          stall_o = 1'b1;
          bubble  = 1'b1;
          held_d  = OP_RET;
          state_d = ST_SECOND;
        end
        default: ;
      endcase
    end else begin
      // Second half only runs if upstream still holds the op that started it.
      if (op == held_q && op == OP_CALL) begin
        we    = 1'b1;
        waddr = sp_q - ONE;
        wdata = DATA_W'(pc_i[15:0]);
        sp_d  = sp_q - TWO;
      end else if (op == held_q && op == OP_RET) begin
        raddr       = sp_q + TWO;
        wb_pc       = 32'({rdata, low_q});
        wb_pc_valid = 1'b1;
        sp_d        = sp_q + TWO;
      end
    end
  end

  // FSM, stack pointer, RET low-word holding register and MEM/WB register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      held_q           <= OP_NOP;
      sp_q             <= SP_INIT;
      low_q            <= '0;
      reg_write_o      <= 1'b0;
      mem_or_reg_o     <= 1'b0;
      dst_or_private_o <= 1'b0;
      reg_dst_o        <= '0;
      alu_data_o       <= '0;
      mem_data_o       <= '0;
      pc_o             <= '0;
      pc_valid_o       <= 1'b0;
    end else begin
      state_q    <= state_d;
      held_q     <= held_d;
      sp_q       <= sp_d;
      low_q      <= low_d;
      pc_o       <= wb_pc;
      pc_valid_o <= wb_pc_valid;
      if (bubble) begin
        reg_write_o      <= 1'b0;
        mem_or_reg_o     <= 1'b0;
        dst_or_private_o <= 1'b0;
        reg_dst_o        <= '0;
        alu_data_o       <= '0;
        mem_data_o       <= '0;
      end else begin
        reg_write_o      <= reg_write_i;
        mem_or_reg_o     <= mem_or_reg_i;
        dst_or_private_o <= dst_or_private_i;
        reg_dst_o        <= reg_dst_i;
        alu_data_o       <= alu_i;
        mem_data_o       <= wb_mem;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for the memory-access stage
module tb_mem_stage;
  import mem_pkg::*;

  typedef logic [82:0] vec_t;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] alu;
    logic [15:0] wd;
    logic [31:0] pc;
    logic        rw;
    logic        mr;
    logic        dp;
    logic [3:0]  dst;
    logic        stall;
    vec_t        exp;
  } stim_t;

  logic        clk;
  logic        rst;
  logic [2:0]  op_i;
  logic [15:0] alu_i;
  logic [15:0] wdata_i;
  logic [31:0] pc_i;
  logic        reg_write_i;
  logic        mem_or_reg_i;
  logic        dst_or_private_i;
  logic [3:0]  reg_dst_i;
  logic        stall_o;
  logic        reg_write_o;
  logic        mem_or_reg_o;
  logic        dst_or_private_o;
  logic [3:0]  reg_dst_o;
  logic [15:0] alu_data_o;
  logic [15:0] mem_data_o;
  logic [31:0] pc_o;
  logic        pc_valid_o;
  logic [10:0] sp_o;

  int   n_vec = 0;
  int   n_err = 0;
  vec_t sb[$];

  mem_stage dut (
    .clk              (clk),
    .rst              (rst),
    .op_i             (op_i),
    .alu_i            (alu_i),
    .wdata_i          (wdata_i),
    .pc_i             (pc_i),
    .reg_write_i      (reg_write_i),
    .mem_or_reg_i     (mem_or_reg_i),
    .dst_or_private_i (dst_or_private_i),
    .reg_dst_i        (reg_dst_i),
    .stall_o          (stall_o),
    .reg_write_o      (reg_write_o),
    .mem_or_reg_o     (mem_or_reg_o),
    .dst_or_private_o (dst_or_private_o),
    .reg_dst_o        (reg_dst_o),
    .alu_data_o       (alu_data_o),
    .mem_data_o       (mem_data_o),
    .pc_o             (pc_o),
    .pc_valid_o       (pc_valid_o),
    .sp_o             (sp_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t outv();
    return {reg_write_o, mem_or_reg_o, dst_or_private_o, reg_dst_o, alu_data_o,
            mem_data_o, pc_valid_o, pc_o, sp_o};
  endfunction

  function automatic vec_t ex(input logic rw, input logic mr, input logic dp,
                              input logic [3:0] dst, input logic [15:0] alu,
                              input logic [15:0] mem, input logic pcv,
                              input logic [31:0] pc, input logic [10:0] sp);
    return {rw, mr, dp, dst, alu, mem, pcv, pc, sp};
  endfunction

  function automatic stim_t row(input logic [2:0] op, input logic [15:0] alu,
                                input logic [15:0] wd, input logic [31:0] pc,
                                input logic rw, input logic mr, input logic dp,
                                input logic [3:0] dst, input logic stall, input vec_t exp);
    stim_t s;
    s.op = op; s.alu = alu; s.wd = wd; s.pc = pc;
    s.rw = rw; s.mr = mr; s.dp = dp; s.dst = dst;
    s.stall = stall; s.exp = exp;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    op_i = s.op; alu_i = s.alu; wdata_i = s.wd; pc_i = s.pc;
    reg_write_i = s.rw; mem_or_reg_i = s.mr; dst_or_private_i = s.dp; reg_dst_i = s.dst;
    sb.push_back(s.exp);
  endtask

  task automatic test_reset();
    vec_t e;
    rst = 1'b1;
    op_i = OP_PUSH; alu_i = 16'hFFFF; wdata_i = 16'hFFFF; pc_i = 32'hFFFF_FFFF;
    reg_write_i = 1'b1; mem_or_reg_i = 1'b1; dst_or_private_i = 1'b1; reg_dst_i = 4'hF;
    sb.push_back(ex(1'b0, 1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 32'h0, 11'h7FF));
    @(posedge clk); @(posedge clk); #1;
    e = sb.pop_front(); n_vec++;
    if (outv() !== e) begin n_err++; $display("FAIL reset_out got=%h exp=%h", outv(), e); end
    rst = 1'b0;
    op_i = OP_NOP;
    #1;
    n_vec++;
    if (stall_o !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
  endtask

  task automatic test_load_store();
    stim_t rows[$];
    vec_t  e;
    rows.push_back(row(OP_STORE, 16'h0010, 16'hBEEF, 32'h0, 1'b1, 1'b0, 1'b0, 4'd3, 1'b0,
                       ex(1'b1, 1'b0, 1'b0, 4'd3, 16'h0010, 16'h0, 1'b0, 32'h0, 11'h7FF)));
    rows.push_back(row(OP_LOAD, 16'h0010, 16'h0, 32'h0, 1'b1, 1'b1, 1'b0, 4'd5, 1'b0,
                       ex(1'b1, 1'b1, 1'b0, 4'd5, 16'h0010, 16'hBEEF, 1'b0, 32'h0, 11'h7FF)));
    rows.push_back(row(OP_NOP, 16'h1234, 16'h9999, 32'h0, 1'b1, 1'b0, 1'b1, 4'd7, 1'b0,
                       ex(1'b1, 1'b0, 1'b1, 4'd7, 16'h1234, 16'h0, 1'b0, 32'h0, 11'h7FF)));
    rows.push_back(row(OP_RSVD, 16'hABCD, 16'h5555, 32'h0, 1'b0, 1'b1, 1'b1, 4'd2, 1'b0,
                       ex(1'b0, 1'b1, 1'b1, 4'd2, 16'hABCD, 16'h0, 1'b0, 32'h0, 11'h7FF)));
    foreach (rows[i]) begin
      drive(rows[i]); #1;
      n_vec++;
      if (stall_o !== rows[i].stall) begin n_err++; $display("FAIL ldst_stall[%0d] got=%b exp=%b", i, stall_o, rows[i].stall); end
      @(posedge clk); #1;
      e = sb.pop_front(); n_vec++;
      if (outv() !== e) begin n_err++; $display("FAIL ldst_out[%0d] got=%h exp=%h", i, outv(), e); end
    end
  endtask

  task automatic test_push_pop();
    stim_t rows[$];
    vec_t  e;
    rows.push_back(row(OP_PUSH, 16'h0001, 16'h1111, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0,
                       ex(1'b0, 1'b0, 1'b0, 4'd0, 16'h0001, 16'h0, 1'b0, 32'h0, 11'h7FE)));
    rows.push_back(row(OP_PUSH, 16'h0002, 16'h2222, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0,
                       ex(1'b0, 1'b0, 1'b0, 4'd0, 16'h0002, 16'h0, 1'b0, 32'h0, 11'h7FD)));
    rows.push_back(row(OP_POP, 16'h0003, 16'h0, 32'h0, 1'b1, 1'b1, 1'b0, 4'd4, 1'b0,
                       ex(1'b1, 1'b1, 1'b0, 4'd4, 16'h0003, 16'h2222, 1'b0, 32'h0, 11'h7FE)));
    rows.push_back(row(OP_POP, 16'h0004, 16'h0, 32'h0, 1'b1, 1'b1, 1'b0, 4'd6, 1'b0,
                       ex(1'b1, 1'b1, 1'b0, 4'd6, 16'h0004, 16'h1111, 1'b0, 32'h0, 11'h7FF)));
    foreach (rows[i]) begin
      drive(rows[i]); #1;
      n_vec++;
      if (stall_o !== rows[i].stall) begin n_err++; $display("FAIL stack_stall[%0d] got=%b exp=%b", i, stall_o, rows[i].stall); end
      @(posedge clk); #1;
      e = sb.pop_front(); n_vec++;
      if (outv() !== e) begin n_err++; $display("FAIL stack_out[%0d] got=%h exp=%h", i, outv(), e); end
    end
  endtask

  task automatic test_call_ret();
    stim_t rows[$];
    vec_t  e;
    rows.push_back(row(OP_CALL, 16'h0055, 16'h0, 32'h00AB_CDEF, 1'b1, 1'b0, 1'b0, 4'd9, 1'b1,
                       ex(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 32'h0, 11'h7FF)));
    rows.push_back(row(OP_CALL, 16'h0055, 16'h0, 32'h00AB_CDEF, 1'b1, 1'b0, 1'b0, 4'd9, 1'b0,
                       ex(1'b1, 1'b0, 1'b0, 4'd9, 16'h0055, 16'h0, 1'b0, 32'h0, 11'h7FD)));
    rows.push_back(row(OP_LOAD, 16'h07FF, 16'h0, 32'h0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0,
                       ex(1'b1, 1'b1, 1'b0, 4'd1, 16'h07FF, 16'h00AB, 1'b0, 32'h0, 11'h7FD)));
    rows.push_back(row(OP_LOAD, 16'h07FE, 16'h0, 32'h0, 1'b1, 1'b1, 1'b0, 4'd2, 1'b0,
                       ex(1'b1, 1'b1, 1'b0, 4'd2, 16'h07FE, 16'hCDEF, 1'b0, 32'h0, 11'h7FD)));
    rows.push_back(row(OP_RET, 16'h0066, 16'h0, 32'h0, 1'b1, 1'b0, 1'b1, 4'd8, 1'b1,
                       ex(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 32'h0, 11'h7FD)));
    rows.push_back(row(OP_RET, 16'h0066, 16'h0, 32'h0, 1'b1, 1'b0, 1'b1, 4'd8, 1'b0,
                       ex(1'b1, 1'b0, 1'b1, 4'd8, 16'h0066, 16'h0, 1'b1, 32'h00AB_CDEF, 11'h7FF)));
    rows.push_back(row(OP_NOP, 16'h0077, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0,
                       ex(1'b0, 1'b0, 1'b0, 4'd0, 16'h0077, 16'h0, 1'b0, 32'h00AB_CDEF, 11'h7FF)));
    foreach (rows[i]) begin
      drive(rows[i]); #1;
      n_vec++;
      if (stall_o !== rows[i].stall) begin n_err++; $display("FAIL callret_stall[%0d] got=%b exp=%b", i, stall_o, rows[i].stall); end
      @(posedge clk); #1;
      e = sb.pop_front(); n_vec++;
      if (outv() !== e) begin n_err++; $display("FAIL callret_out[%0d] got=%h exp=%h", i, outv(), e); end
    end
  endtask

  task automatic test_sp_wrap();
    stim_t rows[$];
    vec_t  e;
    rows.push_back(row(OP_STORE, 16'h0000, 16'h4242, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0,
                       ex(1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0, 1'b0, 32'h00AB_CDEF, 11'h7FF)));
    rows.push_back(row(OP_POP, 16'h0011, 16'h0, 32'h0, 1'b1, 1'b1, 1'b0, 4'd3, 1'b0,
                       ex(1'b1, 1'b1, 1'b0, 4'd3, 16'h0011, 16'h4242, 1'b0, 32'h00AB_CDEF, 11'h000)));
    rows.push_back(row(OP_PUSH, 16'h0022, 16'h7777, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0,
                       ex(1'b0, 1'b0, 1'b0, 4'd0, 16'h0022, 16'h0, 1'b0, 32'h00AB_CDEF, 11'h7FF)));
    rows.push_back(row(OP_LOAD, 16'hF800, 16'h0, 32'h0, 1'b1, 1'b1, 1'b0, 4'd4, 1'b0,
                       ex(1'b1, 1'b1, 1'b0, 4'd4, 16'hF800, 16'h7777, 1'b0, 32'h00AB_CDEF, 11'h7FF)));
    foreach (rows[i]) begin
      drive(rows[i]); #1;
      n_vec++;
      if (stall_o !== rows[i].stall) begin n_err++; $display("FAIL wrap_stall[%0d] got=%b exp=%b", i, stall_o, rows[i].stall); end
      @(posedge clk); #1;
      e = sb.pop_front(); n_vec++;
      if (outv() !== e) begin n_err++; $display("FAIL wrap_out[%0d] got=%h exp=%h", i, outv(), e); end
    end
  endtask

  task automatic test_reset_mid_call();
    stim_t rows[$];
    vec_t  e;
    drive(row(OP_CALL, 16'h0033, 16'h0, 32'h1234_5678, 1'b1, 1'b1, 1'b1, 4'd5, 1'b1,
              ex(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 32'h00AB_CDEF, 11'h7FF)));
    #1;
    n_vec++;
    if (stall_o !== 1'b1) begin n_err++; $display("FAIL midrst_stall1 got=%b exp=1", stall_o); end
    @(posedge clk); #1;
    e = sb.pop_front(); n_vec++;
    if (outv() !== e) begin n_err++; $display("FAIL midrst_bubble got=%h exp=%h", outv(), e); end
    rst = 1'b1;
    sb.push_back(ex(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 32'h0, 11'h7FF));
    @(posedge clk); #1;
    rst = 1'b0;
    op_i = OP_NOP;
    #1;
    e = sb.pop_front(); n_vec++;
    if (outv() !== e) begin n_err++; $display("FAIL midrst_out got=%h exp=%h", outv(), e); end
    n_vec++;
    if (stall_o !== 1'b0) begin n_err++; $display("FAIL midrst_stall0 got=%b exp=0", stall_o); end
    rows.push_back(row(OP_LOAD, 16'h07FF, 16'h0, 32'h0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0,
                       ex(1'b1, 1'b1, 1'b0, 4'd1, 16'h07FF, 16'h1234, 1'b0, 32'h0, 11'h7FF)));
    rows.push_back(row(OP_LOAD, 16'h07FE, 16'h0, 32'h0, 1'b1, 1'b1, 1'b0, 4'd2, 1'b0,
                       ex(1'b1, 1'b1, 1'b0, 4'd2, 16'h07FE, 16'hCDEF, 1'b0, 32'h0, 11'h7FF)));
    foreach (rows[i]) begin
      drive(rows[i]); #1;
      n_vec++;
      if (stall_o !== rows[i].stall) begin n_err++; $display("FAIL midrst_ld_stall[%0d] got=%b exp=%b", i, stall_o, rows[i].stall); end
      @(posedge clk); #1;
      e = sb.pop_front(); n_vec++;
      if (outv() !== e) begin n_err++; $display("FAIL midrst_ld_out[%0d] got=%h exp=%h", i, outv(), e); end
    end
  endtask

  initial begin
    test_reset();
    test_load_store();
    test_push_pop();
    test_call_ret();
    test_sp_wrap();
    test_reset_mid_call();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage 16-bit pipeline. It sits directly upstream of the write-back stage and feeds it.
- Owns the data memory and the stack pointer (SP). Executes LOAD/STORE/PUSH/POP in one cycle and CALL/RET, which move a 32-bit PC, in two cycles.
- Contains the MEM/WB pipeline register, whose outputs drive write-back's regWrite, memOrReg, dstOrPrivate, regDstAddress, memData and aluData.

Parameters:
- DATA_W, 16, datapath word width
- ADDR_W, 11, data-memory address width (depth 2^ADDR_W words)
- SP_INIT, 2^ADDR_W-1, SP value after reset (stack grows downward)

Ports:
- clk  in  1  single clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- op_i  in  3  0 NOP, 1 LOAD, 2 STORE, 3 PUSH, 4 POP, 5 CALL, 6 RET, 7 reserved (treated as NOP)
- alu_i  in  DATA_W  ALU result from EX/MEM; low ADDR_W bits are the LOAD/STORE address
- wdata_i  in  DATA_W  store/push data
- pc_i  in  32  return address for CALL
- reg_write_i, mem_or_reg_i, dst_or_private_i  in  1 each  control bits forwarded to WB
- reg_dst_i  in  4  destination register
- stall_o  out  1  combinational; upstream must hold all inputs stable while high
- reg_write_o, mem_or_reg_o, dst_or_private_o  out  1 each  MEM/WB control
- reg_dst_o  out  4  MEM/WB destination
- alu_data_o, mem_data_o  out  DATA_W  MEM/WB data pair
- pc_o  out  32  popped return PC
- pc_valid_o  out  1  one-cycle pulse; pc_o is valid
- sp_o  out  ADDR_W  current SP, for debug and forwarding

Behaviour:
- Reset (rst=1 at posedge):
  - SP=SP_INIT; FSM goes to IDLE.
  - All MEM/WB outputs go to 0, including pc_valid_o; stall_o=0.
  - Memory contents are not cleared.
  - A reset asserted mid-CALL/RET aborts the operation; any half-written stack word stays in memory.
- Memory: internal array with combinational read and write at posedge. A write in cycle N is visible to a read in cycle N+1.
- MEM/WB register latency is 1 cycle. It captures every cycle unless a bubble is specified.
- Address arithmetic is modulo 2^ADDR_W. SP wraps silently (SP_INIT+1 wraps to 0, 0-1 wraps to SP_INIT); there is no overflow flag.
- FSM states: IDLE and SECOND.
- IDLE, single-cycle ops:
  - NOP: pass controls and alu_i through; mem_data_o=0.
  - LOAD: mem_data_o <= mem[alu_i[ADDR_W-1:0]].
  - STORE: mem[alu_i] <= wdata_i.
  - PUSH: mem[SP] <= wdata_i; SP <= SP-1.
  - POP: mem_data_o <= mem[SP+1]; SP <= SP+1.
  - In all of the above, control bits and reg_dst pass through unchanged, and alu_data_o <= alu_i.
- IDLE, two-cycle ops:
  - CALL: mem[SP] <= pc_i[31:16]; stall_o=1; go to SECOND.
  - RET: low_q <= mem[SP+1]; stall_o=1; go to SECOND.
  - In both, the MEM/WB output is a bubble (reg_write_o=0, pc_valid_o=0).
- SECOND, with the op held by upstream:
  - CALL: mem[SP-1] <= pc_i[15:0]; SP <= SP-2.
  - RET: pc_o <= {mem[SP+2], low_q}; pc_valid_o <= 1; SP <= SP+2.
  - stall_o=0; return to IDLE.
  - Both emit the held control bits and reg_dst into MEM/WB.
- Stack layout after CALL at SP=S: mem[S]=PC high word, mem[S-1]=PC low word, SP=S-2. RET at SP=S-2 restores the exact PC.
- Only one memory op runs per cycle, so read and write never collide on the same address in one cycle.
- Op 7 and any op in SECOND other than the held CALL/RET: behave as NOP (SECOND exits to IDLE).

Decomposition:
- Shared package mem_pkg holds:
  - the op encodings (OP_NOP..OP_RET)
  - the FSM state enum
  - DATA_W/ADDR_W defaults
- One sub-module, data_mem: 2^ADDR_W x DATA_W, combinational read, synchronous write.
- SP, FSM and the MEM/WB register stay in mem_stage.

Test Plan:
- Reset, then STORE alu_i=0x0010 wdata_i=0xBEEF, then LOAD alu_i=0x0010 -> one cycle later mem_data_o=0xBEEF; alu_data_o=0x0010; reg_dst passes through.
- PUSH 0x1111, then PUSH 0x2222, then POP, then POP -> mem_data_o 0x2222 then 0x1111; sp_o goes 0x7FF, 0x7FE, 0x7FD, 0x7FE, 0x7FF.
- CALL pc_i=0x00AB_CDEF -> stall_o=1 for one cycle with a bubble output; mem[0x7FF]=0x00AB, mem[0x7FE]=0xCDEF; sp_o=0x7FD.
- RET following that CALL -> stall_o for one cycle, then pc_valid_o pulses once with pc_o=0x00ABCDEF; sp_o=0x7FF.
- POP at SP=0x7FF -> reads mem[0x000] and sp_o=0x000 (wrap); PUSH at SP=0 -> writes mem[0], then sp_o=0x7FF.
- Assert rst during the SECOND cycle of CALL -> next cycle sp_o=0x7FF, stall_o=0, all outputs 0, FSM in IDLE.
